// File: rtl/sequential_divider.sv
// Unsigned restoring divider: N shift-subtract steps sequenced by a one-hot Moore FSM.
// Shares the start/ready handshake of the sequential shift-add multiplier.
module sequential_divider #(
  parameter int unsigned N = 4
) (
  input  logic         clock,
  input  logic         Reset,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         ready,
  output logic         div_by_zero
);

  localparam int unsigned CW = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic [2:0] {
    INIT     = 3'b001,
    LOAD     = 3'b010,
    SHIFTSUB = 3'b100
  } state_e;

  state_e        state_q, state_d;
  logic [N:0]    a_q, a_d;
  logic [N-1:0]  q_q, q_d;
  logic [N-1:0]  m_q, m_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dbz_q, dbz_d;
  logic [N:0]    shifted_c;
  logic [N:0]    diff_c;

  // State and datapath registers; Reset discards any partial result.
  always_ff @(posedge clock) begin
    if (Reset) begin
      state_q <= INIT;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end

  // Next-state and one restoring iteration; a borrow in diff_c[N] means keep the shifted value.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    q_d       = q_q;
    m_d       = m_q;
    cnt_d     = cnt_q;
    dbz_d     = dbz_q;
    shifted_c = {a_q[N-1:0], q_q[N-1]};
    diff_c    = shifted_c - {1'b0, m_q};

    case (state_q)
      INIT: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        a_d     = '0;
        q_d     = dividend;
        m_d     = divisor;
        cnt_d   = CNT_LAST;
        dbz_d   = (divisor == '0);
        state_d = SHIFTSUB;
      end
      SHIFTSUB: begin
        if (!diff_c[N]) begin
          a_d = diff_c;
          q_d = {q_q[N-2:0], 1'b1};
        end else begin
          a_d = shifted_c;
          q_d = {q_q[N-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = INIT;
      end
      default: state_d = INIT;
    endcase
  end

  assign ready       = (state_q == INIT);
  assign quotient    = q_q;
  assign remainder   = a_q[N-1:0];
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_sequential_divider.sv
// Scoreboard bench for sequential_divider: drivers queue expected results, monitors
// pop and compare on each rising edge of ready (N=4 and N=8 instances).
module tb_sequential_divider;

  logic       clock = 1'b0;
  logic       Reset;
  logic       start, start8;
  logic [3:0] dividend, divisor, quotient, remainder;
  logic       ready, dbz;
  logic [7:0] dividend8, divisor8, quotient8, remainder8;
  logic       ready8, dbz8;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
    int         busy;
  } exp_t;

  exp_t sb4[$];
  exp_t sb8[$];
  exp_t e4, e8;
  int   tests = 0;
  int   fails = 0;
  bit   mon_en = 1'b0;
  logic prev4 = 1'b1, prev8 = 1'b1;
  int   busy4 = 0, busy8 = 0;

  always #5 clock = ~clock;

  sequential_divider #(.N(4)) dut (
    .clock(clock), .Reset(Reset), .start(start),
    .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder),
    .ready(ready), .div_by_zero(dbz)
  );

  sequential_divider #(.N(8)) dut8 (
    .clock(clock), .Reset(Reset), .start(start8),
    .dividend(dividend8), .divisor(divisor8),
    .quotient(quotient8), .remainder(remainder8),
    .ready(ready8), .div_by_zero(dbz8)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor for the N=4 instance: compare on every return to ready.
  always @(negedge clock) begin
    if (mon_en) begin
      if (!ready) busy4++;
      else if (!prev4) begin
        if (sb4.size() == 0) begin
          tests++; fails++;
          $display("FAIL sb4_unexpected: result q=%0h r=%0h with empty queue", quotient, remainder);
        end else begin
          e4 = sb4.pop_front();
          check("q4", quotient, e4.q);
          check("r4", remainder, e4.r);
          check("dbz4", dbz, e4.dbz);
          check("busy4", busy4, e4.busy);
        end
        busy4 = 0;
      end
      prev4 = ready;
    end
  end

  // Monitor for the N=8 instance.
  always @(negedge clock) begin
    if (mon_en) begin
      if (!ready8) busy8++;
      else if (!prev8) begin
        if (sb8.size() == 0) begin
          tests++; fails++;
          $display("FAIL sb8_unexpected: result q=%0h r=%0h with empty queue", quotient8, remainder8);
        end else begin
          e8 = sb8.pop_front();
          check("q8", quotient8, e8.q);
          check("r8", remainder8, e8.r);
          check("dbz8", dbz8, e8.dbz);
          check("busy8", busy8, e8.busy);
        end
        busy8 = 0;
      end
      prev8 = ready8;
    end
  end

  task automatic launch4(input logic [3:0] a, input logic [3:0] b, input bit keep);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clock);
    start = keep;
    @(negedge clock);
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] eq,
                     input logic [3:0] er, input logic ed, input bit keep);
    exp_t e;
    e.q = {4'h0, eq}; e.r = {4'h0, er}; e.dbz = ed; e.busy = 5;
    sb4.push_back(e);
    launch4(a, b, keep);
  endtask

  task automatic wait4();
    int n = 0;
    while (!ready && n < 40) begin
      @(negedge clock);
      n++;
    end
    if (!ready) begin
      tests++; fails++;
      $display("FAIL timeout4: ready=%0b required 1", ready);
    end
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    if (b == 8'h00) begin
      e.q = 8'hFF; e.r = a; e.dbz = 1'b1;
    end else begin
      e.q = a / b; e.r = a % b; e.dbz = 1'b0;
    end
    e.busy = 9;
    sb8.push_back(e);
    dividend8 = a;
    divisor8  = b;
    start8    = 1'b1;
    @(negedge clock);
    start8 = 1'b0;
    @(negedge clock);
  endtask

  task automatic wait8();
    int n = 0;
    while (!ready8 && n < 40) begin
      @(negedge clock);
      n++;
    end
    if (!ready8) begin
      tests++; fails++;
      $display("FAIL timeout8: ready=%0b required 1", ready8);
    end
  endtask

  initial begin
    exp_t e;
    logic [3:0] q_exp, r_exp;
    logic [7:0] ra, rb;
    int n;

    Reset = 1'b1; start = 1'b0; start8 = 1'b0;
    dividend = '0; divisor = '0; dividend8 = '0; divisor8 = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_ready", ready, 1);
    check("reset_q", quotient, 0);
    check("reset_r", remainder, 0);
    check("reset_dbz", dbz, 0);
    check("reset_ready8", ready8, 1);
    Reset = 1'b0;
    mon_en = 1'b1;

    op4(4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 1'b0); wait4();

    // start held high across three ops
    op4(4'd15, 4'd15, 4'd1, 4'd0, 1'b0, 1'b1); wait4();
    op4(4'd5,  4'd7,  4'd0, 4'd5, 1'b0, 1'b1); wait4();
    op4(4'd9,  4'd1,  4'd9, 4'd0, 1'b0, 1'b0); wait4();

    op4(4'd11, 4'd0, 4'hF, 4'hB, 1'b1, 1'b0); wait4();
    op4(4'd8,  4'd2, 4'd4, 4'd0, 1'b0, 1'b0); wait4();

    // inputs churn while busy; result must follow the LOAD-cycle operands
    op4(4'd14, 4'd4, 4'd3, 4'd2, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      start    = ~start;
      dividend = 4'($urandom);
      divisor  = 4'($urandom);
      @(negedge clock);
    end
    start = 1'b0;
    wait4();

    // Reset during the third SHIFTSUB cycle aborts the op
    launch4(4'd9, 4'd2, 1'b0);
    @(negedge clock);
    @(negedge clock);
    e.q = 8'h00; e.r = 8'h00; e.dbz = 1'b0; e.busy = 4;
    sb4.push_back(e);
    Reset = 1'b1;
    @(negedge clock);
    Reset = 1'b0;
    op4(4'd7, 4'd2, 4'd3, 4'd1, 1'b0, 1'b0); wait4();

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (b == 0) begin
          q_exp = 4'hF; r_exp = 4'(a);
        end else begin
          q_exp = 4'(a / b); r_exp = 4'(a % b);
        end
        op4(4'(a), 4'(b), q_exp, r_exp, (b == 0), 1'b0);
        wait4();
      end
    end

    op8(8'd255, 8'd1);   wait8();
    op8(8'd255, 8'd255); wait8();
    op8(8'd200, 8'd0);   wait8();
    op8(8'd17, 8'd200);  wait8();
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      op8(ra, rb);
      wait8();
    end

    n = 0;
    while ((sb4.size() != 0 || sb8.size() != 0) && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("sb4_drained", sb4.size(), 0);
    check("sb8_drained", sb8.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
